// File: rtl/tsp_2opt_sched.sv
// tsp_2opt_sched: sequencer for the 64-city 2-opt tour optimiser.
// It draws random 2-opt candidates (i,j) from a 16-bit LFSR and hands each one
// to the external delta evaluator. If the move is accepted, it reverses
// path[i+1..j] through the path-memory swap port, one swap per transfer.
//
// Ports:
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   start, stop           run control: start pulse, stop level
//   busy, done            run status
//   eval_*                candidate handshake to the delta evaluator
//   res_valid, res_delta  signed delta result from the evaluator
//   swap_*                swap handshake to the path memory
//   temp                  annealing temperature
//   iter_cnt, accept_cnt  completed iterations / accepted moves
//
// Optional feature: define TSP_ANNEAL_EN to also accept non-negative deltas
// that are within temp, when the LFSR top nibble is zero.
module tsp_2opt_sched #(
    parameter int unsigned N_CITIES  = 64,
    parameter int unsigned IDX_W     = 6,       // 2*IDX_W must not exceed 16
    parameter int unsigned DELTA_W   = 32,
    parameter int unsigned MAX_ITER  = 0,       // 0: run until stop
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic               eval_valid,
    output logic [IDX_W-1:0]   eval_i,
    output logic [IDX_W-1:0]   eval_j,
    input  logic               eval_ready,
    input  logic               res_valid,
    input  logic [DELTA_W-1:0] res_delta,
    output logic               swap_valid,
    output logic [IDX_W-1:0]   swap_a,
    output logic [IDX_W-1:0]   swap_b,
    input  logic               swap_ready,
    input  logic [DELTA_W-1:0] temp,
    output logic [31:0]        iter_cnt,
    output logic [31:0]        accept_cnt
);

    // An all-zero seed would lock the LFSR.
    localparam logic [15:0]      SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CITIES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_GEN    = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_DECIDE = 3'd4,
        S_SWAP   = 3'd5,
        S_NEXT   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [15:0]        r_lfsr;
    logic [IDX_W-1:0]   r_i;
    logic [IDX_W-1:0]   r_j;
    logic [IDX_W-1:0]   r_lo;
    logic [IDX_W-1:0]   r_hi;
    logic [DELTA_W-1:0] r_delta;
    logic               r_accepted;
    logic               r_busy;
    logic               r_done;
    logic               r_eval_valid;
    logic               r_swap_valid;
    logic [31:0]        r_iter_cnt;
    logic [31:0]        r_accept_cnt;

    logic [IDX_W-1:0]   w_a;
    logic [IDX_W-1:0]   w_b;
    logic [IDX_W-1:0]   w_ci;
    logic [IDX_W-1:0]   w_cj;
    logic [IDX_W-1:0]   w_lo_inc;
    logic [IDX_W-1:0]   w_hi_dec;
    logic               w_lfsr_fb;
    logic               w_cand_ok;
    logic               w_accept;
    logic               w_swap_fire;
    logic               w_swap_last;
    logic [31:0]        w_iter_inc;
    logic               w_limit_hit;

    logic               w_lfsr_step;
    logic               w_cand_load;
    logic               w_res_load;
    logic               w_decide;
    logic               w_cnt_clr;
    logic               w_iter_step;

    // Fibonacci LFSR, taps 16,14,13,11.
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // Candidate pair taken from the current LFSR value.
    assign w_a  = r_lfsr[IDX_W-1:0];
    assign w_b  = r_lfsr[2*IDX_W-1:IDX_W];
    assign w_ci = (w_a < w_b) ? w_a : w_b;
    assign w_cj = (w_a < w_b) ? w_b : w_a;

    // Segments shorter than 2, or the whole-tour reversal, change nothing.
    assign w_cand_ok = (32'(w_cj) < N_CITIES)
                    && ((w_cj - w_ci) >= IDX_W'(2))
                    && !((w_ci == '0) && (w_cj == LAST_IDX));

    // Acceptance: strictly negative delta (sign bit), plus optional annealing.
`ifdef TSP_ANNEAL_EN
    assign w_accept = r_delta[DELTA_W-1]
                   || ((r_delta <= temp) && (r_lfsr[15:12] == 4'h0));
`else
    logic w_unused;
    assign w_unused = ^{temp, r_delta[DELTA_W-2:0]};
    assign w_accept = r_delta[DELTA_W-1];
`endif

    // Swap walker: the last transfer is the one that makes lo and hi meet or cross.
    assign w_swap_fire = r_swap_valid && swap_ready;
    assign w_lo_inc    = r_lo + IDX_W'(1);
    assign w_hi_dec    = r_hi - IDX_W'(1);
    assign w_swap_last = (w_lo_inc >= w_hi_dec);

    assign w_iter_inc  = r_iter_cnt + 32'd1;
    assign w_limit_hit = (MAX_ITER != 0) && (w_iter_inc == MAX_ITER);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_step = 1'b0;
        w_cand_load = 1'b0;
        w_res_load  = 1'b0;
        w_decide    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_iter_step = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                w_lfsr_step = 1'b1;
                if (stop) begin
                    w_state_nxt = S_DONE;
                end else if (w_cand_ok) begin
                    w_cand_load = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (eval_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (res_valid) begin
                    w_res_load  = 1'b1;
                    w_state_nxt = S_DECIDE;
                end
            end
            S_DECIDE: begin
                w_decide    = 1'b1;
                w_state_nxt = w_accept ? S_SWAP : S_NEXT;
            end
            S_SWAP: begin
                // stop is not honoured here, so a started reversal always completes.
                if (w_swap_fire && w_swap_last) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_iter_step = 1'b1;
                w_state_nxt = (stop || w_limit_hit) ? S_DONE : S_GEN;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr       <= SEED;
            r_i          <= '0;
            r_j          <= '0;
            r_lo         <= '0;
            r_hi         <= '0;
            r_delta      <= '0;
            r_accepted   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_eval_valid <= 1'b0;
            r_swap_valid <= 1'b0;
            r_iter_cnt   <= '0;
            r_accept_cnt <= '0;
        end else begin
            if (w_lfsr_step) begin
                r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            end
            if (w_cand_load) begin
                r_i <= w_ci;
                r_j <= w_cj;
            end
            if (w_res_load) begin
                r_delta <= res_delta;
            end
            if (w_decide) begin
                r_accepted <= w_accept;
            end
            if (w_decide && w_accept) begin
                r_lo <= r_i + IDX_W'(1);
                r_hi <= r_j;
            end else if (w_swap_fire) begin
                r_lo <= w_lo_inc;
                r_hi <= w_hi_dec;
            end
            if (w_cnt_clr) begin
                r_iter_cnt   <= '0;
                r_accept_cnt <= '0;
            end else if (w_iter_step) begin
                r_iter_cnt <= w_iter_inc;
                if (r_accepted) begin
                    r_accept_cnt <= r_accept_cnt + 32'd1;
                end
            end
            r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
            r_done       <= (w_state_nxt == S_DONE);
            r_eval_valid <= (w_state_nxt == S_ISSUE);
            r_swap_valid <= (w_state_nxt == S_SWAP);
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign eval_valid = r_eval_valid;
    assign eval_i     = r_i;
    assign eval_j     = r_j;
    assign swap_valid = r_swap_valid;
    assign swap_a     = r_lo;
    assign swap_b     = r_hi;
    assign iter_cnt   = r_iter_cnt;
    assign accept_cnt = r_accept_cnt;

endmodule

// File: tb/tb_tsp_2opt_sched.sv
// tb_tsp_2opt_sched: directed bench for tsp_2opt_sched (MAX_ITER=4, seed 16'h0283,
// which makes the first draw the pair (3,10)). A small LFSR model predicts
// every candidate pair; the swap sequence and counters follow from the pair
// and the delta the bench returns.
module tb_tsp_2opt_sched;

    localparam logic [15:0] SEED = 16'h0283;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        busy;
    logic        done;
    logic        eval_valid;
    logic [5:0]  eval_i;
    logic [5:0]  eval_j;
    logic        eval_ready;
    logic        res_valid;
    logic [31:0] res_delta;
    logic        swap_valid;
    logic [5:0]  swap_a;
    logic [5:0]  swap_b;
    logic        swap_ready;
    logic [31:0] temp;
    logic [31:0] iter_cnt;
    logic [31:0] accept_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] m_lfsr;
    int          exp_iter;
    int          exp_acc;
    logic [5:0]  last_i;
    logic [5:0]  last_j;
    logic [5:0]  sw_a[$];
    logic [5:0]  sw_b[$];
    logic [5:0]  ri;
    logic [5:0]  rj;

    always #5 clk = ~clk;

    tsp_2opt_sched #(
        .N_CITIES (64),
        .IDX_W    (6),
        .DELTA_W  (32),
        .MAX_ITER (4),
        .LFSR_SEED(SEED)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .done      (done),
        .eval_valid(eval_valid),
        .eval_i    (eval_i),
        .eval_j    (eval_j),
        .eval_ready(eval_ready),
        .res_valid (res_valid),
        .res_delta (res_delta),
        .swap_valid(swap_valid),
        .swap_a    (swap_a),
        .swap_b    (swap_b),
        .swap_ready(swap_ready),
        .temp      (temp),
        .iter_cnt  (iter_cnt),
        .accept_cnt(accept_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_done"},       32'(done),       32'd0);
        chk({tag, "_eval_valid"}, 32'(eval_valid), 32'd0);
        chk({tag, "_eval_i"},     32'(eval_i),     32'd0);
        chk({tag, "_eval_j"},     32'(eval_j),     32'd0);
        chk({tag, "_swap_valid"}, 32'(swap_valid), 32'd0);
        chk({tag, "_swap_a"},     32'(swap_a),     32'd0);
        chk({tag, "_swap_b"},     32'(swap_b),     32'd0);
        chk({tag, "_iter_cnt"},   32'(iter_cnt),   32'd0);
        chk({tag, "_accept_cnt"}, 32'(accept_cnt), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Model draw: the LFSR advances once per GEN cycle, legal or not.
    task automatic next_pair(output logic [5:0] pi, output logic [5:0] pj);
        logic [5:0] a;
        logic [5:0] b;
        bit         ok;
        ok = 1'b0;
        pi = '0;
        pj = '0;
        for (int g = 0; g < 10000 && !ok; g++) begin
            a  = m_lfsr[5:0];
            b  = m_lfsr[11:6];
            pi = (a < b) ? a : b;
            pj = (a < b) ? b : a;
            ok = ((pj - pi) >= 6'd2) && !((pi == 6'd0) && (pj == 6'd63));
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    endtask

    task automatic wait_eval();
        int c;
        c = 0;
        while (eval_valid !== 1'b1 && c < 200) begin
            step();
            c++;
        end
        chk("eval_valid_timeout", 32'(c < 200), 32'd1);
    endtask

    // One full iteration: candidate, optional eval stall, result, swaps, counters.
    task automatic do_iter(input int delta, input int eval_stall,
                           input bit swap_toggle, input bit stop_in_swap);
        logic [5:0] ei;
        logic [5:0] ej;
        bit         acc;
        int         exp_n;
        int         exp_lo;
        int         exp_hi;
        int         n;
        int         c;
        sw_a.delete();
        sw_b.delete();
        next_pair(ei, ej);
        wait_eval();
        last_i = eval_i;
        last_j = eval_j;
        chk("eval_i", 32'(eval_i), 32'(ei));
        chk("eval_j", 32'(eval_j), 32'(ej));
        chk("pair_gap", 32'((int'(eval_j) - int'(eval_i)) >= 2), 32'd1);
        chk("pair_not_full", 32'(!(eval_i == 6'd0 && eval_j == 6'd63)), 32'd1);
        for (int k = 0; k < eval_stall; k++) begin
            step();
            chk("stall_eval_valid", 32'(eval_valid), 32'd1);
            chk("stall_eval_i", 32'(eval_i), 32'(ei));
            chk("stall_eval_j", 32'(eval_j), 32'(ej));
        end
        eval_ready = 1'b1;
        step();
        eval_ready = 1'b0;
        chk("eval_valid_drop", 32'(eval_valid), 32'd0);
        step();
        res_valid = 1'b1;
        res_delta = 32'(delta);
        step();
        res_valid = 1'b0;
        acc = (delta < 0);
`ifdef TSP_ANNEAL_EN
        acc = acc || ((delta >= 0) && (32'(delta) <= temp) && (m_lfsr[15:12] == 4'h0));
`endif
        exp_n  = acc ? (int'(ej) - int'(ei)) / 2 : 0;
        exp_lo = int'(ei) + 1;
        exp_hi = int'(ej);
        n = 0;
        c = 0;
        while (!(eval_valid === 1'b1 || done === 1'b1) && c < 300) begin
            swap_ready = swap_toggle ? (c % 2 == 1) : 1'b1;
            if (swap_valid === 1'b1) begin
                if (stop_in_swap) stop = 1'b1;
                chk("swap_expected", 32'(n < exp_n), 32'd1);
                chk("swap_a", 32'(swap_a), 32'(exp_lo));
                chk("swap_b", 32'(swap_b), 32'(exp_hi));
                if (swap_ready) begin
                    sw_a.push_back(swap_a);
                    sw_b.push_back(swap_b);
                    n++;
                    exp_lo++;
                    exp_hi--;
                end
            end
            step();
            c++;
        end
        swap_ready = 1'b0;
        chk("iter_end_timeout", 32'(c < 300), 32'd1);
        chk("swap_count", 32'(n), 32'(exp_n));
        exp_iter++;
        if (acc) exp_acc++;
        chk("iter_cnt", iter_cnt, 32'(exp_iter));
        chk("accept_cnt", accept_cnt, 32'(exp_acc));
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        eval_ready = 1'b0;
        res_valid  = 1'b0;
        res_delta  = '0;
        swap_ready = 1'b0;
        temp       = '0;
        repeat (3) step();
        check_zero("reset");
        rst_n = 1'b1;
        step();
        chk("idle_busy", 32'(busy), 32'd0);
        m_lfsr   = SEED;
        exp_iter = 0;
        exp_acc  = 0;

        // Run 1: accepted (3,10), rejected, stalled/toggled accept, limit reached.
        pulse_start();
        do_iter(-5, 0, 1'b0, 1'b0);
        chk("first_i", 32'(last_i), 32'd3);
        chk("first_j", 32'(last_j), 32'd10);
        chk("first_swaps", 32'(sw_a.size()), 32'd3);
        if (sw_a.size() == 3) begin
            chk("sw0_a", 32'(sw_a[0]), 32'd4);
            chk("sw0_b", 32'(sw_b[0]), 32'd10);
            chk("sw1_a", 32'(sw_a[1]), 32'd5);
            chk("sw1_b", 32'(sw_b[1]), 32'd9);
            chk("sw2_a", 32'(sw_a[2]), 32'd6);
            chk("sw2_b", 32'(sw_b[2]), 32'd8);
        end
        chk("first_iter_cnt", iter_cnt, 32'd1);
        chk("first_accept_cnt", accept_cnt, 32'd1);
        do_iter(0, 0, 1'b0, 1'b0);
        do_iter(-1, 10, 1'b1, 1'b0);
        do_iter(-1, 0, 1'b0, 1'b0);
        chk("run1_done", 32'(done), 32'd1);
        chk("run1_busy", 32'(busy), 32'd0);
        chk("run1_iter", iter_cnt, 32'd4);
        repeat (5) step();
        chk("done_hold", 32'(done), 32'd1);
        chk("done_hold_iter", iter_cnt, 32'd4);
        chk("done_hold_acc", accept_cnt, 32'(exp_acc));

        // Run 2: always -1, limit of 4; new start clears counters.
        pulse_start();
        exp_iter = 0;
        exp_acc  = 0;
        chk("restart_iter", iter_cnt, 32'd0);
        chk("restart_acc", accept_cnt, 32'd0);
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) do_iter(-1, 0, 1'b1, 1'b0);
        chk("run2_done", 32'(done), 32'd1);
        chk("run2_busy", 32'(busy), 32'd0);
        chk("run2_iter", iter_cnt, 32'd4);
        chk("run2_acc", accept_cnt, 32'd4);

        // Run 3: stop raised mid-swap; the reversal still completes.
        pulse_start();
        exp_iter = 0;
        exp_acc  = 0;
        do_iter(-1, 0, 1'b1, 1'b1);
        stop = 1'b0;
        chk("stop_done", 32'(done), 32'd1);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_iter", iter_cnt, 32'd1);

        // Reset in the middle of a swap.
        pulse_start();
        next_pair(ri, rj);
        wait_eval();
        chk("rst_run_eval_i", 32'(eval_i), 32'(ri));
        chk("rst_run_eval_j", 32'(eval_j), 32'(rj));
        eval_ready = 1'b1;
        step();
        eval_ready = 1'b0;
        res_valid = 1'b1;
        res_delta = 32'hFFFF_FFFF;
        step();
        res_valid = 1'b0;
        step();
        chk("rst_in_swap", 32'(swap_valid), 32'd1);
        rst_n = 1'b0;
        step();
        check_zero("midswap_reset");
        repeat (2) step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_reset_swap", 32'(swap_valid), 32'd0);
            chk("post_reset_busy", 32'(busy), 32'd0);
        end
        m_lfsr = SEED;

        // 250 runs of 4 rejected moves: 1000 candidates checked against the model.
        for (int r = 0; r < 250; r++) begin
            pulse_start();
            exp_iter = 0;
            exp_acc  = 0;
            for (int k = 0; k < 4; k++) begin
                do_iter(0, 0, 1'b0, 1'b0);
                if (r == 0 && k == 0) begin
                    chk("reseed_i", 32'(last_i), 32'd3);
                    chk("reseed_j", 32'(last_j), 32'd10);
                end
            end
            chk("legal_run_done", 32'(done), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
